// File: rtl/add_mop_csv_acc.sv
// Streaming multi-operand carry-save accumulator: each beat is folded into a
// redundant (S, C) pair with no carry propagation; packets freeze into an output register.
module add_mop_csv_acc_csa #(
  parameter int width = 16
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic [width-1:0] c,
  output logic [width-1:0] s,
  output logic [width-1:0] cy
);
  assign s  = a ^ b ^ c;
  // The MSB carry leaves the word, so the majority is only formed below it.
  assign cy = {(a[width-2:0] & b[width-2:0]) | (a[width-2:0] & c[width-2:0]) |
               (b[width-2:0] & c[width-2:0]), 1'b0};
endmodule

module add_mop_csv_acc #(
  parameter  int width     = 16,
  parameter  int depth     = 4,
  parameter  int speed     = 1,
  parameter  int max_beats = 16,
  localparam int cnt_w     = $clog2(max_beats + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [depth*width-1:0] in_ops_i,
  input  logic                   in_last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [width-1:0]       out_s_o,
  output logic [width-1:0]       out_c_o,
  output logic [width-1:0]       out_sum_o,
  output logic [cnt_w-1:0]       out_beats_o
);
  localparam int n_ops = depth + 2;

  // CSAs per level: a chain retires one operand per level, a tree takes every full triple.
  function automatic int grp(input int n);
    if (n <= 2) return 0;
    return (speed != 0) ? n / 3 : 1;
  endfunction

  function automatic int cnt_at(input int l);
    int n;
    n = n_ops;
    for (int i = 0; i < l; i++) n -= grp(n);
    return n;
  endfunction

  function automatic int lvls();
    int n, k;
    n = n_ops;
    k = 0;
    for (int i = 0; i < 1024; i++)
      if (n > 2) begin
        n -= grp(n);
        k++;
      end
    return k;
  endfunction

  localparam int n_lvl = lvls();

  logic [width-1:0]            acc_s, acc_c;
  logic [cnt_w-1:0]            cnt;
  logic [depth-1:0][width-1:0] ops;
  logic [width-1:0]            s_nxt, c_nxt;
  logic                        fire_in, fire_out, term;

  assign ops = in_ops_i;

  for (genvar l = 0; l <= n_lvl; l++) begin : gen_lvl
    localparam int nin  = cnt_at(l);
    localparam int ng   = grp(nin);
    localparam int nout = nin - ng;
    logic [nin-1:0][width-1:0]  v;
    logic [nout-1:0][width-1:0] nv;
    if (l == 0) begin : g_src
      assign v = {acc_c, acc_s, ops};
    end else begin : g_link
      assign v = gen_lvl[l-1].nv;
    end
    for (genvar g = 0; g < ng; g++) begin : gen_csa
      add_mop_csv_acc_csa #(.width(width)) u_csa (
        .a (v[3*g]),
        .b (v[3*g+1]),
        .c (v[3*g+2]),
        .s (nv[2*g]),
        .cy(nv[2*g+1])
      );
    end
    if (nin > 3*ng) begin : g_pass
      assign nv[nout-1:2*ng] = v[nin-1:3*ng];
    end
  end

  // The last level always comes from a single CSA, so slot 1 is a shifted carry.
  assign s_nxt = gen_lvl[n_lvl].nv[0];
  assign c_nxt = gen_lvl[n_lvl].nv[1];

  assign in_ready_o = !clear_i && (!out_valid_o || out_ready_i);
  assign fire_in    = in_valid_i && in_ready_o;
  assign fire_out   = out_valid_o && out_ready_i;
  assign term       = in_last_i || (cnt == cnt_w'(max_beats - 1));
  assign out_sum_o  = out_s_o + out_c_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_s       <= '0;
      acc_c       <= '0;
      cnt         <= '0;
      out_s_o     <= '0;
      out_c_o     <= '0;
      out_beats_o <= '0;
      out_valid_o <= 1'b0;
    end else begin
      if (fire_out) out_valid_o <= 1'b0;
      if (clear_i) begin
        acc_s <= '0;
        acc_c <= '0;
        cnt   <= '0;
      end else if (fire_in) begin
        if (term) begin
          out_s_o     <= s_nxt;
          out_c_o     <= c_nxt;
          out_beats_o <= cnt + cnt_w'(1);
          out_valid_o <= 1'b1;
          acc_s       <= '0;
          acc_c       <= '0;
          cnt         <= '0;
        end else begin
          acc_s <= s_nxt;
          acc_c <= c_nxt;
          cnt   <= cnt + cnt_w'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_add_mop_csv_acc.sv
// Scoreboard bench: runs the chain and tree variants side by side on shared stimulus.
module tb_add_mop_csv_acc;
  localparam int W = 8;
  localparam int D = 4;
  localparam int MB = 4;
  localparam int CW = 3;

  typedef struct {
    int sum;
    int beats;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, clear, in_valid, in_last, out_ready;
  logic [D*W-1:0] in_ops;
  logic           rdy0, rdy1, ov0, ov1;
  logic [W-1:0]   s0, c0, sum0, s1, c1, sum1;
  logic [CW-1:0]  b0, b1;

  exp_t q0[$];
  exp_t q1[$];
  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  add_mop_csv_acc #(.width(W), .depth(D), .speed(0), .max_beats(MB)) u_chain (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .in_ops_i(in_ops), .in_last_i(in_last), .out_valid_o(ov0), .out_ready_i(out_ready),
    .out_s_o(s0), .out_c_o(c0), .out_sum_o(sum0), .out_beats_o(b0));

  add_mop_csv_acc #(.width(W), .depth(D), .speed(1), .max_beats(MB)) u_tree (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_ops_i(in_ops), .in_last_i(in_last), .out_valid_o(ov1), .out_ready_i(out_ready),
    .out_s_o(s1), .out_c_o(c1), .out_sum_o(sum1), .out_beats_o(b1));

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int sum, input int beats);
    exp_t e;
    e.sum = sum;
    e.beats = beats;
    q0.push_back(e);
    q1.push_back(e);
  endtask

  // Monitors: pop and compare whenever a result is consumed.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov0 && out_ready) begin
      if (q0.size() == 0) chk("chain_unexpected_result", 1, 0);
      else begin
        e = q0.pop_front();
        chk("chain_sum", int'(sum0), e.sum);
        chk("chain_s_plus_c", int'(W'(s0 + c0)), e.sum);
        chk("chain_beats", int'(b0), e.beats);
        chk("chain_c_bit0", int'(c0[0]), 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov1 && out_ready) begin
      if (q1.size() == 0) chk("tree_unexpected_result", 1, 0);
      else begin
        e = q1.pop_front();
        chk("tree_sum", int'(sum1), e.sum);
        chk("tree_s_plus_c", int'(W'(s1 + c1)), e.sum);
        chk("tree_beats", int'(b1), e.beats);
        chk("tree_c_bit0", int'(c1[0]), 0);
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; the task returns just after the fire edge.
  task automatic beat(input int a, input int b, input int c, input int d, input logic last);
    bit got;
    in_ops   = {W'(d), W'(c), W'(b), W'(a)};
    in_last  = last;
    in_valid = 1'b1;
    got = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rdy0 && rdy1) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_last = 1'b1; in_ops = {8'd9, 8'd9, 8'd9, 8'd9};
    repeat (2) @(negedge clk);
    chk("rst_chain_valid", int'(ov0), 0);
    chk("rst_tree_valid", int'(ov1), 0);
    chk("rst_chain_s", int'(s0), 0);
    chk("rst_chain_c", int'(c0), 0);
    chk("rst_chain_sum", int'(sum0), 0);
    chk("rst_chain_beats", int'(b0), 0);
    chk("rst_tree_sum", int'(sum1), 0);
    chk("rst_tree_beats", int'(b1), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_chain_ready", int'(rdy0), 1);
    chk("post_rst_tree_ready", int'(rdy1), 1);
    @(posedge clk); #1;

    // single-beat packet
    push(10, 1);
    beat(1, 2, 3, 4, 1'b1);
    chk("single_valid", int'(ov0 & ov1), 1);

    // three beats: 100 + 400 + 4 = 504 -> 248
    push(248, 3);
    beat(10, 20, 30, 40, 1'b0);
    beat(100, 100, 100, 100, 1'b0);
    beat(1, 1, 1, 1, 1'b1);

    // limit termination: 4 * 1020 = 4080 -> 240, then a fresh packet
    push(240, 4);
    repeat (4) beat(255, 255, 255, 255, 1'b0);
    push(4, 1);
    beat(1, 1, 1, 1, 1'b1);
    idle(2);

    // backpressure: result held while out_ready is low
    out_ready = 1'b0;
    push(28, 1);
    beat(7, 7, 7, 7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready_low", int'(rdy0 | rdy1), 0);
      chk("bp_valid_held", int'(ov0 & ov1), 1);
      chk("bp_chain_sum", int'(sum0), 28);
      chk("bp_tree_sum", int'(sum1), 28);
      chk("bp_beats", int'(b0), 1);
      @(posedge clk); #1;
    end
    // double fire: old result leaves while the new one loads
    out_ready = 1'b1;
    push(5, 1);
    beat(5, 0, 0, 0, 1'b1);
    chk("b2b_valid_stays", int'(ov0 & ov1), 1);
    idle(2);

    // clear mid-packet: the beat presented with clear is refused
    beat(50, 50, 50, 50, 1'b0);
    clear = 1'b1;
    in_valid = 1'b1; in_last = 1'b1; in_ops = {8'd9, 8'd9, 8'd9, 8'd9};
    @(negedge clk);
    chk("clear_ready_low", int'(rdy0 | rdy1), 0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clear_no_result", int'(ov0 | ov1), 0);
    @(posedge clk); #1;
    push(4, 1);
    beat(1, 1, 1, 1, 1'b1);
    idle(2);

    // same with reset instead of clear
    beat(50, 50, 50, 50, 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b1; in_last = 1'b1; in_ops = {8'd9, 8'd9, 8'd9, 8'd9};
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_result", int'(ov0 | ov1), 0);
    @(posedge clk); #1;
    push(4, 1);
    beat(1, 1, 1, 1, 1'b1);
    idle(3);

    chk("chain_queue_drained", q0.size(), 0);
    chk("tree_queue_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
